// File: rtl/clave_check.sv
// clave_check: access-code checker for the keypad front end.
// Watches the scanner's key stream, collects digits, and compares them with
// CODE when '#' is pressed. It drives the grant, deny and lockout indications
// and counts the failed attempts.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   rst         in   1  synchronous reset, active-low
//   found       in   1  key-valid level from the scanner (may stay high while held)
//   num         in   4  key code: 0-9 digit, 10 '*' clear, 11 '#' enter, 12-15 ignored
//   granted     out  1  code accepted, high HOLD_CYCLES cycles
//   denied      out  1  code rejected, high HOLD_CYCLES cycles
//   locked      out  1  lockout active, high LOCK_CYCLES cycles
//   tries_left  out  4  remaining attempts before lockout
//   count       out  4  digits currently in the buffer
//   busy        out  1  high whenever not IDLE; keys are ignored then
module clave_check #(
  parameter int unsigned           CODE_LEN    = 10,
  parameter logic [4*CODE_LEN-1:0] CODE        = 40'h0123456789,
  parameter int unsigned           MAX_TRIES   = 3,
  parameter int unsigned           HOLD_CYCLES = 50000000,
  parameter int unsigned           LOCK_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       found,
  input  logic [3:0] num,
  output logic       granted,
  output logic       denied,
  output logic       locked,
  output logic [3:0] tries_left,
  output logic [3:0] count,
  output logic       busy
);

  localparam int unsigned BUF_W = 4 * CODE_LEN;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TMR_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_GRANT,
    S_DENY,
    S_LOCK
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [BUF_W-1:0]   r_buf, w_buf_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [CNT_W-1:0]   r_tries, w_tries_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               r_found_q;
  logic               r_granted, r_denied, r_locked, r_busy;
  logic               w_event;
  logic               w_match;

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_buf_nxt   = r_buf;
    w_count_nxt = r_count;
    w_tries_nxt = r_tries;
    w_timer_nxt = r_timer;

    // A held key gives a single event on its rising level.
    w_event = found & ~r_found_q;
    w_match = (r_count == CNT_W'(CODE_LEN)) && (r_buf == CODE);

    case (r_state)
      S_IDLE: begin
        if (w_event) begin
          if (num <= 4'd9) begin
            // Buffer saturates when full; extra digits are dropped, not shifted in.
            if (r_count < CNT_W'(CODE_LEN)) begin
              w_buf_nxt   = {r_buf[BUF_W-5:0], num};
              w_count_nxt = r_count + CNT_W'(1);
            end
          end else if (num == 4'd10) begin
            w_buf_nxt   = '0;
            w_count_nxt = '0;
          end else if (num == 4'd11) begin
            w_state_nxt = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        w_buf_nxt   = '0;
        w_count_nxt = '0;
        if (w_match) begin
          w_state_nxt = S_GRANT;
          w_tries_nxt = CNT_W'(MAX_TRIES);
          w_timer_nxt = TMR_W'(HOLD_CYCLES);
        end else begin
          w_tries_nxt = r_tries - CNT_W'(1);
          if (w_tries_nxt == '0) begin
            w_state_nxt = S_LOCK;
            w_timer_nxt = TMR_W'(LOCK_CYCLES);
          end else begin
            w_state_nxt = S_DENY;
            w_timer_nxt = TMR_W'(HOLD_CYCLES);
          end
        end
      end

      // Timer holds the cycles left in the state, including the current one.
      S_GRANT, S_DENY: begin
        if (r_timer <= TMR_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end

      S_LOCK: begin
        if (r_timer <= TMR_W'(1)) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_tries_nxt = CNT_W'(MAX_TRIES);
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_buf     <= '0;
      r_count   <= '0;
      r_tries   <= CNT_W'(MAX_TRIES);
      r_timer   <= '0;
      r_found_q <= 1'b0;
      r_granted <= 1'b0;
      r_denied  <= 1'b0;
      r_locked  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_buf     <= w_buf_nxt;
      r_count   <= w_count_nxt;
      r_tries   <= w_tries_nxt;
      r_timer   <= w_timer_nxt;
      r_found_q <= found;
      r_granted <= (w_state_nxt == S_GRANT);
      r_denied  <= (w_state_nxt == S_DENY);
      r_locked  <= (w_state_nxt == S_LOCK);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign granted    = r_granted;
  assign denied     = r_denied;
  assign locked     = r_locked;
  assign tries_left = r_tries;
  assign count      = r_count;
  assign busy       = r_busy;

endmodule

// File: tb/tb_clave_check.sv
// tb_clave_check: drives directed and random key streams into clave_check and
// compares every cycle against a timeline model built from a digit queue.
module tb_clave_check;

  localparam int unsigned CL = 4;
  localparam int unsigned MT = 3;
  localparam int unsigned HC = 4;
  localparam int unsigned LC = 16;
  localparam logic [15:0] CODE_V = 16'h1234;

  localparam int K_NONE  = 0;
  localparam int K_GRANT = 1;
  localparam int K_DENY  = 2;
  localparam int K_LOCK  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       found;
  logic [3:0] num;
  logic       granted, denied, locked, busy;
  logic [3:0] tries_left, count;

  clave_check #(
    .CODE_LEN    (CL),
    .CODE        (CODE_V),
    .MAX_TRIES   (MT),
    .HOLD_CYCLES (HC),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .found      (found),
    .num        (num),
    .granted    (granted),
    .denied     (denied),
    .locked     (locked),
    .tries_left (tries_left),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: entered digits, attempts left, and a timeline of the current
  // verdict (check edge, verdict kind, first edge back in IDLE).
  int unsigned m_q[$];
  int          m_tries;
  bit          m_prev;
  int          m_busy_end;
  int          m_check_at;
  int          m_out_start;
  int          m_kind;
  int          t = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input logic [3:0] n);
    bit          ev;
    bit          match;
    logic [31:0] v;
    int          dur;
    if (!r) begin
      m_q.delete();
      m_tries     = MT;
      m_prev      = 1'b0;
      m_busy_end  = -1;
      m_check_at  = -1;
      m_out_start = -1;
      m_kind      = K_NONE;
      return;
    end
    ev     = f && !m_prev;
    m_prev = f;
    if (m_check_at == t) begin
      v = 0;
      foreach (m_q[i]) v = v * 16 + m_q[i];
      match = (m_q.size() == CL) && (v == 32'(CODE_V));
      m_q.delete();
      if (match) begin
        m_tries = MT;
        m_kind  = K_GRANT;
        dur     = HC;
      end else begin
        m_tries--;
        m_kind = (m_tries == 0) ? K_LOCK : K_DENY;
        dur    = (m_tries == 0) ? LC : HC;
      end
      m_out_start = t;
      m_busy_end  = t + dur;
      m_check_at  = -1;
    end else if (t == m_busy_end && m_kind == K_LOCK) begin
      m_tries = MT;
    end else if (t > m_busy_end && ev) begin
      if (n <= 9) begin
        if (m_q.size() < CL) m_q.push_back(int'(n));
      end else if (n == 10) begin
        m_q.delete();
      end else if (n == 11) begin
        m_check_at = t + 1;
        m_busy_end = t + 1;
        m_kind     = K_NONE;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit f, input logic [3:0] n);
    bit act;
    rst   = r;
    found = f;
    num   = n;
    @(posedge clk);
    t++;
    model_step(r, f, n);
    #1;
    act = (t >= m_out_start) && (t < m_busy_end);
    check_eq("granted",    32'(granted),    32'(act && m_kind == K_GRANT));
    check_eq("denied",     32'(denied),     32'(act && m_kind == K_DENY));
    check_eq("locked",     32'(locked),     32'(act && m_kind == K_LOCK));
    check_eq("busy",       32'(busy),       32'(t < m_busy_end));
    check_eq("tries_left", 32'(tries_left), 32'(m_tries));
    check_eq("count",      32'(count),      32'(m_q.size()));
    check_eq("onehot",     32'(32'(granted) + 32'(denied) + 32'(locked) <= 1), 32'd1);
  endtask

  task automatic key(input logic [3:0] k);
    cycle(1'b1, 1'b1, k);
    cycle(1'b1, 1'b0, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 4'd0);
  endtask

  task automatic code_seq(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d);
  endtask

  initial begin
    rst   = 1'b0;
    found = 1'b0;
    num   = 4'd0;
    cycle(1'b0, 1'b0, 4'd0);
    cycle(1'b0, 1'b1, 4'd3);
    idle(2);

    // Correct code, then wrong, then short entry.
    code_seq(4'd1, 4'd2, 4'd3, 4'd4); key(4'd11); idle(8);
    code_seq(4'd1, 4'd2, 4'd3, 4'd5); key(4'd11); idle(8);
    key(4'd1); key(4'd2); key(4'd3); key(4'd11); idle(8);
    // Third failure locks; keys during lock are dropped.
    key(4'd9); key(4'd11); key(4'd1); key(4'd2); key(4'd11); idle(20);

    // Three fresh failures in a row.
    for (int i = 0; i < 3; i++) begin
      key(4'd5); key(4'd11); idle(7);
    end
    idle(14);

    // Saturation: fifth digit ignored, code still matches.
    code_seq(4'd1, 4'd2, 4'd3, 4'd4); key(4'd9); key(4'd11); idle(8);
    key(4'd7); key(4'd10); key(4'd13); idle(2);

    // Held key gives one event.
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 4'd5);
    idle(2); key(4'd10);

    // Key held across the return to IDLE.
    code_seq(4'd1, 4'd2, 4'd3, 4'd4); key(4'd11);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 4'd1);
    idle(2);

    // Reset during GRANT.
    code_seq(4'd1, 4'd2, 4'd3, 4'd4); key(4'd11);
    idle(3);
    cycle(1'b0, 1'b0, 4'd0);
    idle(3);

    // Randomized key stream with occasional full code entries and resets.
    for (int a = 0; a < 600; a++) begin
      int unsigned sel;
      int unsigned hold;
      int unsigned gap;
      logic [3:0]  k;
      sel = $urandom_range(0, 99);
      if (sel < 12) begin
        code_seq(4'd1, 4'd2, 4'd3, 4'd4);
        k = 4'd11;
      end else if (sel < 24) k = 4'd11;
      else if (sel < 29) k = 4'd10;
      else if (sel < 33) k = 4'($urandom_range(12, 15));
      else if (sel < 34) begin
        cycle(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        continue;
      end else k = 4'($urandom_range(0, 9));
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 4);
      for (int h = 0; h < int'(hold); h++) cycle(1'b1, 1'b1, k);
      for (int g = 0; g < int'(gap); g++) cycle(1'b1, 1'b0, 4'($urandom_range(0, 15)));
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
